// File: rtl/mult_seq_param.sv
// Iterative sign-magnitude multiplier: one A_CHUNK x B_CHUNK partial product per cycle.
// Result and a one-cycle done pulse are issued N_A*N_B+1 cycles after start is accepted.
module mult_seq_param #(
   parameter int A_W     = 32,
   parameter int B_W     = 32,
   parameter int A_CHUNK = 8,
   parameter int B_CHUNK = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 signed_mode,
   input  logic [A_W-1:0]                       a,
   input  logic [B_W-1:0]                       b,
   output logic                                 busy,
   output logic                                 done,
   output logic [A_W+B_W-1:0]                   product,
   output logic [$clog2(A_W/A_CHUNK)-1:0]       a_idx,
   output logic [$clog2(B_W/B_CHUNK)-1:0]       b_idx
);
   localparam int N_A  = A_W / A_CHUNK;
   localparam int N_B  = B_W / B_CHUNK;
   localparam int P_W  = A_W + B_W;
   localparam int IA_W = $clog2(N_A);
   localparam int IB_W = $clog2(N_B);
   localparam logic [IA_W-1:0] I_LAST = IA_W'(N_A - 1);
   localparam logic [IB_W-1:0] J_LAST = IB_W'(N_B - 1);

   typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

   state_t                     state;
   logic [A_W-1:0]             a_mag;
   logic [B_W-1:0]             b_mag;
   logic                       neg;
   logic [P_W-1:0]             acc;

   logic [A_W-1:0]             a_abs;
   logic [B_W-1:0]             b_abs;
   logic [A_CHUNK-1:0]         a_sl;
   logic [B_CHUNK-1:0]         b_sl;
   logic [A_CHUNK+B_CHUNK-1:0] pp;
   logic [P_W-1:0]             pp_sh;

   // The most negative operand maps to 2^(W-1), which still fits unsigned in W bits.
   always_comb begin
      a_abs = (signed_mode && a[A_W-1]) ? (~a + A_W'(1)) : a;
      b_abs = (signed_mode && b[B_W-1]) ? (~b + B_W'(1)) : b;
      a_sl  = A_CHUNK'(a_mag >> (int'(a_idx) * A_CHUNK));
      b_sl  = B_CHUNK'(b_mag >> (int'(b_idx) * B_CHUNK));
      pp    = {{B_CHUNK{1'b0}}, a_sl} * {{A_CHUNK{1'b0}}, b_sl};
      pp_sh = P_W'(pp) << (int'(a_idx) * A_CHUNK + int'(b_idx) * B_CHUNK);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         a_idx   <= '0;
         b_idx   <= '0;
         a_mag   <= '0;
         b_mag   <= '0;
         neg     <= 1'b0;
         acc     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_mag <= a_abs;
                  b_mag <= b_abs;
                  neg   <= signed_mode & (a[A_W-1] ^ b[B_W-1]);
                  acc   <= '0;
                  a_idx <= '0;
                  b_idx <= '0;
                  busy  <= 1'b1;
                  state <= MUL;
               end
            end
            MUL: begin
               acc <= acc + pp_sh;
               // a slice is the inner loop; indices wrap to 0 so they read 0 once idle
               if (a_idx == I_LAST) begin
                  a_idx <= '0;
                  if (b_idx == J_LAST) begin
                     b_idx <= '0;
                     state <= FIN;
                  end else begin
                     b_idx <= b_idx + IB_W'(1);
                  end
               end else begin
                  a_idx <= a_idx + IA_W'(1);
               end
            end
            FIN: begin
               product <= neg ? (~acc + P_W'(1)) : acc;
               done    <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_seq_param.sv
// Randomised and directed checks of mult_seq_param against an arithmetic reference model.
module tb_mult_seq_param;
   localparam int NPP = 8;   // 4 a-slices x 2 b-slices at default parameters

   logic        clk = 1'b0;
   logic        reset;
   logic        start, signed_mode;
   logic [31:0] a, b;
   logic        busy, done;
   logic [63:0] product;
   logic [1:0]  a_idx;
   logic [0:0]  b_idx;

   logic        start_s, sm_s;
   logic [15:0] a_s;
   logic [7:0]  b_s;
   logic        busy_s, done_s;
   logic [23:0] product_s;
   logic [1:0]  a_idx_s;
   logic [0:0]  b_idx_s;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mult_seq_param dut (
      .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
      .a(a), .b(b), .busy(busy), .done(done), .product(product),
      .a_idx(a_idx), .b_idx(b_idx)
   );

   mult_seq_param #(.A_W(16), .B_W(8), .A_CHUNK(4), .B_CHUNK(4)) dut_s (
      .clk(clk), .reset(reset), .start(start_s), .signed_mode(sm_s),
      .a(a_s), .b(b_s), .busy(busy_s), .done(done_s), .product(product_s),
      .a_idx(a_idx_s), .b_idx(b_idx_s)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input bit sm);
      longint sx, sy;
      if (sm) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         return 64'(sx * sy);
      end
      return {32'b0, x} * {32'b0, y};
   endfunction

   function automatic logic [23:0] ref_mul_s(input logic [15:0] x, input logic [7:0] y, input bit sm);
      longint sx, sy;
      if (sm) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = longint'({48'b0, x});
         sy = longint'({56'b0, y});
      end
      return 24'(sx * sy);
   endfunction

   // Called #1 after an edge; returns #1 after the accepting edge.
   task automatic launch(input logic [31:0] ta, input logic [31:0] tb, input bit sm);
      a = ta; b = tb; signed_mode = sm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Walks the operation from the accepting edge to the done cycle, optionally
   // disturbing start/operands while busy; returns in the done cycle with start=0.
   task automatic finish_op(input logic [63:0] exp, input string tag, input bit wiggle);
      int  m = 0, busy_n = 0, idx_err = 0;
      bit  got = 1'b0;
      while (m < 40) begin
         if (done) begin got = 1'b1; break; end
         if (busy) busy_n++;
         if (m < NPP && (int'(a_idx) != m % 4 || int'(b_idx) != m / 4)) idx_err++;
         if (wiggle) begin
            start = 1'($urandom); a = $urandom; b = $urandom; signed_mode = 1'($urandom);
         end
         @(posedge clk); #1;
         m++;
      end
      start = 1'b0;
      chk({tag, "_done"}, 64'(got), 64'd1);
      chk({tag, "_lat"}, 64'(m), 64'(NPP + 1));
      chk({tag, "_busy"}, 64'(busy_n), 64'(NPP + 1));
      chk({tag, "_idx"}, 64'(idx_err), 64'd0);
      chk({tag, "_prod"}, product, exp);
   endtask

   task automatic idle_check(input logic [63:0] exp, input string tag);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, {62'b0, busy, done}, 64'd0);
      chk({tag, "_hold"}, product, exp);
      chk({tag, "_idle_idx"}, {61'b0, a_idx, b_idx}, 64'd0);
   endtask

   task automatic run_small(input logic [15:0] ta, input logic [7:0] tb, input bit sm,
                            input logic [23:0] exp, input string tag);
      int m = 0;
      a_s = ta; b_s = tb; sm_s = sm; start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      while (!done_s && m < 40) begin
         @(posedge clk); #1;
         m++;
      end
      chk({tag, "_lat"}, 64'(m), 64'(NPP + 1));
      chk({tag, "_prod"}, {40'b0, product_s}, {40'b0, exp});
   endtask

   initial begin
      logic [63:0] prev, exp;
      logic [31:0] ra, rb;
      logic [15:0] sa;
      logic [7:0]  sb;
      bit          rs;
      int          dn;

      reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
      start_s = 1'b0; sm_s = 1'b0; a_s = '0; b_s = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_ctl", {62'b0, busy, done}, 64'd0);
      chk("rst_prod", product, 64'd0);
      chk("rst_idx", {61'b0, a_idx, b_idx}, 64'd0);

      launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      finish_op(64'hFFFF_FFFE_0000_0001, "u_max", 1'b0);
      idle_check(64'hFFFF_FFFE_0000_0001, "u_max");

      launch(32'hFFFF_FFFF, 32'd5, 1'b1);
      finish_op(64'hFFFF_FFFF_FFFF_FFFB, "s_m1x5", 1'b1);
      idle_check(64'hFFFF_FFFF_FFFF_FFFB, "s_m1x5");

      launch(32'hFFFF_FFFF, 32'd5, 1'b0);
      finish_op(64'h0000_0004_FFFF_FFFB, "u_m1x5", 1'b1);

      // back-to-back: new start issued in the done cycle
      launch(32'h8000_0000, 32'h8000_0000, 1'b1);
      chk("b2b_old_prod", product, 64'h0000_0004_FFFF_FFFB);
      finish_op(64'h4000_0000_0000_0000, "s_minxmin", 1'b1);
      launch(32'h8000_0000, 32'd1, 1'b1);
      chk("b2b_old_prod2", product, 64'h4000_0000_0000_0000);
      finish_op(64'hFFFF_FFFF_8000_0000, "s_minx1", 1'b1);
      idle_check(64'hFFFF_FFFF_8000_0000, "s_minx1");

      // reset during the 4th MUL cycle
      launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort_ctl", {62'b0, busy, done}, 64'd0);
      chk("abort_prod", product, 64'd0);
      dn = 0;
      repeat (15) begin @(posedge clk); #1; if (done || busy) dn++; end
      chk("abort_quiet", 64'(dn), 64'd0);
      launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
      finish_op(ref_mul(32'h1234_5678, 32'h9ABC_DEF0, 1'b0), "post_rst", 1'b0);

      prev = product;
      for (int k = 0; k < 12; k++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom);
         if (k % 4 == 1) ra = 32'h8000_0000;
         if (k % 4 == 2) rb = 32'(int'($urandom_range(0, 3)));
         exp = ref_mul(ra, rb, rs);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
         end
         launch(ra, rb, rs);
         chk($sformatf("rnd%0d_old", k), product, prev);
         finish_op(exp, $sformatf("rnd%0d", k), 1'b1);
         prev = exp;
      end

      run_small(16'hABCD, 8'hEF, 1'b0, 24'h00A0_6463, "sm_dir");
      for (int k = 0; k < 6; k++) begin
         sa = 16'($urandom); sb = 8'($urandom); rs = 1'($urandom);
         run_small(sa, sb, rs, ref_mul_s(sa, sb, rs), $sformatf("sm_rnd%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
